// File: rtl/ddr3_wr_arbiter.sv
// Write-side round-robin scheduler between two camera write FIFOs and the AXI master user port.
// Optional burst watchdog enabled by defining WR_TIMEOUT_EN.
module ddr3_wr_arbiter #(
    parameter logic [27:0] CH_STRIDE      = 28'h0200000,
    parameter logic [27:0] BANK_STRIDE    = 28'h0100000,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         ui_clk,
    input  logic         rst_n,
    input  logic         init_done,
    input  logic         pingpang_en,
    input  logic [27:0]  addr_wd_min,
    input  logic [27:0]  addr_wd_max,
    input  logic [9:0]   wd_burst_len,
    input  logic         wd_load_1,
    input  logic         wd_load_2,
    input  logic [10:0]  wfifo_rcount_1,
    input  logic [10:0]  wfifo_rcount_2,
    input  logic [127:0] wfifo_rd_data_1,
    input  logic [127:0] wfifo_rd_data_2,
    output logic         wfifo_rd_en_1,
    output logic         wfifo_rd_en_2,
    output logic         wd_req,
    output logic [27:0]  wd_addr,
    output logic [9:0]   wd_len,
    input  logic         wd_fifo_re,
    output logic [127:0] wd_ddr3_data,
    input  logic         wd_finish,
    output logic         bank_done_1,
    output logic         bank_done_2,
    output logic         wd_overrun,
    output logic         wd_timeout
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARB  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d, rr_q, rr_d;
    logic [1:0][27:0] offset_q, offset_d;
    logic [1:0]       bank_q, bank_d, bank_done_q, bank_done_d;
    logic [1:0]       load_pend_q, load_pend_d, load_clr;
    logic [1:0]       ld_meta_q, ld_sync_q, ld_prev_q, ld_rise, ready;
    logic             req_q, req_d, overrun_q, overrun_d;
    logic [27:0]      addr_q, addr_d;
    logic [9:0]       len_q, len_d;
    logic             gnt;
    logic [27:0]      frame_size;
    logic [28:0]      adv, adv_end;
    logic             tmo_expire, skip_adv;

    assign ld_rise     = ld_sync_q & ~ld_prev_q;
    assign ready[0]    = (wfifo_rcount_1 >= {1'b0, wd_burst_len}) && !load_pend_q[0];
    assign ready[1]    = (wfifo_rcount_2 >= {1'b0, wd_burst_len}) && !load_pend_q[1];
    assign frame_size  = addr_wd_max - addr_wd_min;
    assign adv         = {1'b0, offset_q[sel_q]} + {19'd0, wd_burst_len};
    assign adv_end     = adv + {19'd0, wd_burst_len};
    assign load_pend_d = (load_pend_q & ~load_clr) | ld_rise;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        offset_d    = offset_q;
        bank_d      = bank_q;
        bank_done_d = bank_done_q;
        load_clr    = 2'b00;
        overrun_d   = overrun_q;
        req_d       = 1'b0;
        addr_d      = addr_q;
        len_d       = len_q;
        gnt         = (&ready) ? rr_q : ready[1];
        case (state_q)
            ST_IDLE: if (init_done) state_d = ST_ARB;
            ST_ARB: begin
                // Frame restarts for channels not currently bursting take effect here
                for (int i = 0; i < 2; i++) begin
                    if (load_pend_q[i]) begin
                        offset_d[i] = 28'd0;
                        load_clr[i] = 1'b1;
                        if (pingpang_en) begin
                            bank_done_d[i] = bank_q[i];
                            bank_d[i]      = ~bank_q[i];
                        end else begin
                            bank_d[i] = 1'b0;
                        end
                    end
                end
                if (|ready) begin
                    sel_d   = gnt;
                    req_d   = 1'b1;
                    len_d   = wd_burst_len;
                    addr_d  = addr_wd_min + (gnt ? CH_STRIDE : 28'd0)
                            + ((bank_q[gnt] && pingpang_en) ? BANK_STRIDE : 28'd0)
                            + offset_q[gnt];
                    state_d = ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_DATA;
            ST_DATA: if (wd_finish || tmo_expire) state_d = ST_DONE;
            ST_DONE: begin
                if (!skip_adv) begin
                    if (adv_end > {1'b0, frame_size}) begin
                        offset_d[sel_q] = 28'd0;
                        overrun_d       = 1'b1;
                    end else begin
                        offset_d[sel_q] = adv[27:0];
                    end
                end
                if (load_pend_q[sel_q]) begin
                    offset_d[sel_q] = 28'd0;
                    load_clr[sel_q] = 1'b1;
                    if (pingpang_en) begin
                        bank_done_d[sel_q] = bank_q[sel_q];
                        bank_d[sel_q]      = ~bank_q[sel_q];
                    end else begin
                        bank_d[sel_q] = 1'b0;
                    end
                end
                rr_d    = ~sel_q;
                state_d = ST_ARB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            rr_q        <= 1'b0;
            offset_q    <= '0;
            bank_q      <= 2'b00;
            bank_done_q <= 2'b00;
            load_pend_q <= 2'b00;
            ld_meta_q   <= 2'b00;
            ld_sync_q   <= 2'b00;
            ld_prev_q   <= 2'b00;
            req_q       <= 1'b0;
            overrun_q   <= 1'b0;
            addr_q      <= 28'd0;
            len_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            offset_q    <= offset_d;
            bank_q      <= bank_d;
            bank_done_q <= bank_done_d;
            load_pend_q <= load_pend_d;
            ld_meta_q   <= {wd_load_2, wd_load_1};
            ld_sync_q   <= ld_meta_q;
            ld_prev_q   <= ld_sync_q;
            req_q       <= req_d;
            overrun_q   <= overrun_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
        end
    end

`ifdef WR_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit_q, timeout_q;

    assign tmo_expire = (state_q == ST_DATA) && ((32'(tmo_cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
    assign skip_adv   = tmo_hit_q;
    assign wd_timeout = timeout_q;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 16'd0;
            tmo_hit_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_REQ) tmo_cnt_q <= 16'd0;
            else if (state_q == ST_DATA) tmo_cnt_q <= tmo_cnt_q + 16'd1;
            // Remembers whether the last DATA exit was forced, read in DONE
            if (state_q == ST_DATA) tmo_hit_q <= tmo_expire;
            if (tmo_expire) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_expire = 1'b0;
    assign skip_adv   = 1'b0;
    assign wd_timeout = 1'b0;
`endif

    assign wfifo_rd_en_1 = (state_q == ST_DATA) && wd_fifo_re && !sel_q;
    assign wfifo_rd_en_2 = (state_q == ST_DATA) && wd_fifo_re && sel_q;
    assign wd_ddr3_data  = sel_q ? wfifo_rd_data_2 : wfifo_rd_data_1;
    assign wd_req        = req_q;
    assign wd_addr       = addr_q;
    assign wd_len        = len_q;
    assign bank_done_1   = bank_done_q[0];
    assign bank_done_2   = bank_done_q[1];
    assign wd_overrun    = overrun_q;
endmodule

// File: tb/tb_ddr3_wr_arbiter.sv
// Directed bench for ddr3_wr_arbiter: a small AXI-master model serves each burst and
// checks address, channel steering, load re-alignment, overrun and latency.
module tb_ddr3_wr_arbiter;
    localparam logic [127:0] D1 = {4{32'h1111_aaaa}};
    localparam logic [127:0] D2 = {4{32'h2222_bbbb}};

    logic         ui_clk, rst_n, init_done, pingpang_en;
    logic [27:0]  addr_wd_min, addr_wd_max;
    logic [9:0]   wd_burst_len;
    logic         wd_load_1, wd_load_2;
    logic [10:0]  wfifo_rcount_1, wfifo_rcount_2;
    logic [127:0] wfifo_rd_data_1, wfifo_rd_data_2;
    logic         wfifo_rd_en_1, wfifo_rd_en_2;
    logic         wd_req;
    logic [27:0]  wd_addr;
    logic [9:0]   wd_len;
    logic         wd_fifo_re;
    logic [127:0] wd_ddr3_data;
    logic         wd_finish;
    logic         bank_done_1, bank_done_2, wd_overrun, wd_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    ddr3_wr_arbiter #(.TIMEOUT_CYCLES(100)) dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_done(init_done), .pingpang_en(pingpang_en),
        .addr_wd_min(addr_wd_min), .addr_wd_max(addr_wd_max), .wd_burst_len(wd_burst_len),
        .wd_load_1(wd_load_1), .wd_load_2(wd_load_2),
        .wfifo_rcount_1(wfifo_rcount_1), .wfifo_rcount_2(wfifo_rcount_2),
        .wfifo_rd_data_1(wfifo_rd_data_1), .wfifo_rd_data_2(wfifo_rd_data_2),
        .wfifo_rd_en_1(wfifo_rd_en_1), .wfifo_rd_en_2(wfifo_rd_en_2),
        .wd_req(wd_req), .wd_addr(wd_addr), .wd_len(wd_len), .wd_fifo_re(wd_fifo_re),
        .wd_ddr3_data(wd_ddr3_data), .wd_finish(wd_finish),
        .bank_done_1(bank_done_1), .bank_done_2(bank_done_2),
        .wd_overrun(wd_overrun), .wd_timeout(wd_timeout)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic do_reset(input logic [27:0] mx, input bit pp, input logic [10:0] c1,
                            input logic [10:0] c2);
        rst_n = 1'b0;
        init_done = 1'b1;
        pingpang_en = pp;
        addr_wd_min = 28'd0;
        addr_wd_max = mx;
        wd_burst_len = 10'd64;
        wfifo_rcount_1 = c1;
        wfifo_rcount_2 = c2;
        wfifo_rd_data_1 = D1;
        wfifo_rd_data_2 = D2;
        wd_fifo_re = 1'b0;
        wd_finish = 1'b0;
        wd_load_1 = 1'b0;
        wd_load_2 = 1'b0;
        repeat (3) @(negedge ui_clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge ui_clk);
            wd_finish = 1'b0;
        end
    endtask

    // Returns at the negedge where wd_req is high; cyc counts negedges waited
    task automatic wait_req(input string tag, output int cyc);
        bit found = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 300 && !found; c++) begin
            @(negedge ui_clk);
            wd_finish = 1'b0;
            if (wd_req) begin
                found = 1'b1;
                cyc = c;
            end
        end
        check({tag, "_req_seen"}, found, 1'b1);
    endtask

    task automatic burst(input string tag, input int ch, input logic [27:0] addr,
                         input bit load_late, output int cyc);
        int beats = 0, n1 = 0, n2 = 0, bad = 0, c = 0;
        wait_req(tag, cyc);
        check({tag, "_addr"}, wd_addr, addr);
        check({tag, "_len"}, wd_len, wd_burst_len);
        while (beats < int'(wd_burst_len) && c < 200) begin
            @(negedge ui_clk);
            wd_fifo_re = !(c == 3 || c == 7);
            if (load_late && beats == int'(wd_burst_len) - 2 && wd_fifo_re) wd_load_1 = 1'b1;
            #1;
            if (c == 0) begin
                check({tag, "_req_1cyc"}, wd_req, 1'b0);
                check({tag, "_data"}, wd_ddr3_data, (ch == 1) ? D1 : D2);
            end
            if (wfifo_rd_en_1 !== (wd_fifo_re && ch == 1)) bad++;
            if (wfifo_rd_en_2 !== (wd_fifo_re && ch == 2)) bad++;
            n1 += int'(wfifo_rd_en_1);
            n2 += int'(wfifo_rd_en_2);
            if (wd_fifo_re) beats++;
            c++;
        end
        check({tag, "_mirror"}, bad, 0);
        check({tag, "_n_en1"}, n1, (ch == 1) ? 64 : 0);
        check({tag, "_n_en2"}, n2, (ch == 2) ? 64 : 0);
        @(negedge ui_clk);
        wd_fifo_re = 1'b0;
        wd_finish = 1'b1;
    endtask

    initial begin
        // Reset values and IDLE hold while init_done is low
        do_reset(28'h1000, 1'b0, 11'd64, 11'd0);
        rst_n = 1'b0;
        init_done = 1'b0;
        #1;
        check("rst_req", wd_req, 1'b0);
        check("rst_addr", wd_addr, 28'd0);
        check("rst_len", wd_len, 10'd0);
        check("rst_flags", {wfifo_rd_en_1, wfifo_rd_en_2, bank_done_1, bank_done_2,
                            wd_overrun, wd_timeout}, 6'd0);
        @(negedge ui_clk);
        rst_n = 1'b1;
        wd_fifo_re = 1'b1;
        begin
            int reqs = 0, ens = 0;
            repeat (10) begin
                @(negedge ui_clk);
                reqs += int'(wd_req);
                ens += int'(wfifo_rd_en_1) + int'(wfifo_rd_en_2);
            end
            check("idle_no_req", reqs, 0);
            check("idle_no_rd_en", ens, 0);
        end
        wd_fifo_re = 1'b0;
        init_done = 1'b1;

        // Single channel sequential bursts
        burst("s1_b1", 1, 28'h0, 1'b0, lat);
        burst("s1_b2", 1, 28'h40, 1'b0, lat);
        check("s1_finish_to_req", lat, 3);
        check("s1_timeout_low", wd_timeout, 1'b0);

        // Round-robin with both channels ready
        do_reset(28'h1000, 1'b0, 11'd200, 11'd200);
        burst("s2_b1", 1, 28'h0, 1'b0, lat);
        burst("s2_b2", 2, 28'h0200000, 1'b0, lat);
        burst("s2_b3", 1, 28'h40, 1'b0, lat);

        // Ping-pong bank switching on frame load while channel is idle
        do_reset(28'h1000, 1'b1, 11'd200, 11'd0);
        burst("s3_b1", 1, 28'h0, 1'b0, lat);
        burst("s3_b2", 1, 28'h40, 1'b0, lat);
        wfifo_rcount_1 = 11'd0;
        idle(2);
        wd_load_1 = 1'b1;
        idle(3);
        wd_load_1 = 1'b0;
        idle(5);
        check("s3_bank_done_a", bank_done_1, 1'b0);
        wfifo_rcount_1 = 11'd200;
        burst("s3_b3", 1, 28'h0100000, 1'b0, lat);
        wfifo_rcount_1 = 11'd0;
        idle(2);
        wd_load_1 = 1'b1;
        idle(3);
        wd_load_1 = 1'b0;
        idle(5);
        check("s3_bank_done_b", bank_done_1, 1'b1);
        check("s3_bank_done_2", bank_done_2, 1'b0);
        wfifo_rcount_1 = 11'd200;
        burst("s3_b4", 1, 28'h0, 1'b0, lat);

        // Load edge coinciding with wd_finish, ping-pong off
        do_reset(28'h1000, 1'b0, 11'd200, 11'd0);
        burst("s4_b1", 1, 28'h0, 1'b0, lat);
        burst("s4_b2", 1, 28'h40, 1'b1, lat);
        wd_load_1 = 1'b0;
        burst("s4_b3", 1, 28'h0, 1'b0, lat);
        burst("s4_b4", 1, 28'h40, 1'b0, lat);
        check("s4_bank_done", bank_done_1, 1'b0);

        // Overrun wrap with a two-burst frame
        do_reset(28'h80, 1'b0, 11'd200, 11'd0);
        burst("s5_b1", 1, 28'h0, 1'b0, lat);
        burst("s5_b2", 1, 28'h40, 1'b0, lat);
        check("s5_overrun_a", wd_overrun, 1'b0);
        burst("s5_b3", 1, 28'h0, 1'b0, lat);
        check("s5_overrun_b", wd_overrun, 1'b1);

`ifdef WR_TIMEOUT_EN
        // Watchdog forces DONE without advancing the offset
        do_reset(28'h1000, 1'b0, 11'd64, 11'd0);
        wait_req("s6", lat);
        check("s6_addr", wd_addr, 28'h0);
        idle(99);
        check("s6_timeout_early", wd_timeout, 1'b0);
        idle(2);
        check("s6_timeout_set", wd_timeout, 1'b1);
        burst("s6_b2", 1, 28'h0, 1'b0, lat);
        check("s6_timeout_sticky", wd_timeout, 1'b1);
`endif

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
